// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: funct3 widths, FSM states, access legality.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_access_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Legal encoding for the direction and naturally aligned for its width.
    function automatic logic access_ok(input logic [2:0] f3,
                                       input logic       is_store,
                                       input logic [1:0] off);
        logic legal;
        logic aligned;
        case (f3)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_BU, F3_HU:     legal = !is_store;
            default:          legal = 1'b0;
        endcase
        case (f3[1:0])
            2'b01:   aligned = (off[0] == 1'b0);
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Byte lane handling: request byte enables, store data replication, load lane extract/extend.
// Latency: purely combinational.
// Backpressure: none; request and response sides are independent input groups.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      req_funct3_i,
    input  logic [1:0]      req_off_i,
    input  logic            req_is_store_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [2:0]      rsp_funct3_i,
    input  logic [1:0]      rsp_off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] load_data_o
);

    logic [XLEN-1:0] lane;

    // Byte enables by access width; store data replicated so every lane carries it.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        case (req_funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << req_off_i;
                wdata_o = XLEN'({4{store_data_i[7:0]}});
            end
            2'b01: begin
                be_o    = 4'b0011 << req_off_i;
                wdata_o = XLEN'({2{store_data_i[15:0]}});
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase
        if (!req_is_store_i) begin
            wdata_o = '0;
        end
    end

    // Shift the addressed lane down to bit 0, then sign- or zero-extend.
    always_comb begin
        lane        = rdata_i >> {rsp_off_i, 3'b000};
        load_data_o = rdata_i;
        case (rsp_funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_H:    load_data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: ALU pass-through or one outstanding load/store on a req/ack bus, registered WB bundle.
// Latency: 1 cycle pass-through; loads 2+ cycles (accept cycle, then ack cycle).
// Backpressure: stall_o holds upstream while an access is accepted or in flight, released on ack/timeout.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic            rd_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_re_i,
    input  logic            mem_we_i,
    input  logic [2:0]      opfunc3_i,
    output logic            stall_o,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_ack_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_we_o,
    output logic            misalign_o,
    output logic            bus_err_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            dbus_req_q, dbus_we_q;
    logic [XLEN-1:0] dbus_addr_q, dbus_wdata_q;
    logic [3:0]      dbus_be_q;
    logic [4:0]      rd_addr_q, cap_rd_addr_q;
    logic [XLEN-1:0] rd_data_q;
    logic            rd_we_q, cap_rd_we_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            misalign_q, bus_err_q;

    logic            mem_op, req_ok, accept, reject, ack_hit, to_hit;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata, load_data;

    mem_lane_align #(.XLEN(XLEN)) u_align (
        .req_funct3_i   (opfunc3_i),
        .req_off_i      (mem_addr_i[1:0]),
        .req_is_store_i (mem_we_i),
        .store_data_i   (rd_data_i),
        .be_o           (lane_be),
        .wdata_o        (lane_wdata),
        .rsp_funct3_i   (f3_q),
        .rsp_off_i      (off_q),
        .rdata_i        (dbus_rdata_i),
        .load_data_o    (load_data)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: enter BUSY on a legal access, leave on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (ack_hit || to_hit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode and stall: a store wins over a simultaneous load; ack beats a same-cycle timeout.
    always_comb begin
        mem_op  = mem_re_i | mem_we_i;
        req_ok  = access_ok(opfunc3_i, mem_we_i, mem_addr_i[1:0]);
        accept  = (state_q == ST_IDLE) && mem_op && req_ok;
        reject  = (state_q == ST_IDLE) && mem_op && !req_ok;
        ack_hit = (state_q == ST_BUSY) && dbus_ack_i;
        to_hit  = (state_q == ST_BUSY) && !dbus_ack_i && (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);
        stall_o = accept || ((state_q == ST_BUSY) && !ack_hit && !to_hit);
    end

    // Bus request, writeback bundle and status pulses.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q         <= '0;
            dbus_req_q    <= 1'b0;
            dbus_we_q     <= 1'b0;
            dbus_addr_q   <= '0;
            dbus_be_q     <= 4'b0000;
            dbus_wdata_q  <= '0;
            rd_addr_q     <= 5'd0;
            rd_data_q     <= '0;
            rd_we_q       <= 1'b0;
            cap_rd_addr_q <= 5'd0;
            cap_rd_we_q   <= 1'b0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            misalign_q    <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (accept) begin
                    dbus_req_q    <= 1'b1;
                    dbus_we_q     <= mem_we_i;
                    dbus_addr_q   <= {mem_addr_i[XLEN-1:2], 2'b00};
                    dbus_be_q     <= lane_be;
                    dbus_wdata_q  <= lane_wdata;
                    cap_rd_addr_q <= rd_addr_i;
                    cap_rd_we_q   <= rd_we_i;
                    f3_q          <= opfunc3_i;
                    off_q         <= mem_addr_i[1:0];
                    cnt_q         <= '0;
                    rd_we_q       <= 1'b0;
                end else if (reject) begin
                    misalign_q <= 1'b1;
                    rd_we_q    <= 1'b0;
                end else begin
                    rd_addr_q <= rd_addr_i;
                    rd_data_q <= rd_data_i;
                    rd_we_q   <= rd_we_i;
                end
            end else begin
                if (ack_hit) begin
                    dbus_req_q <= 1'b0;
                    if (dbus_we_q) begin
                        rd_we_q <= 1'b0;
                    end else begin
                        rd_addr_q <= cap_rd_addr_q;
                        rd_data_q <= load_data;
                        rd_we_q   <= cap_rd_we_q;
                    end
                end else if (to_hit) begin
                    dbus_req_q <= 1'b0;
                    bus_err_q  <= 1'b1;
                    rd_we_q    <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign dbus_req_o   = dbus_req_q;
    assign dbus_we_o    = dbus_we_q;
    assign dbus_addr_o  = dbus_addr_q;
    assign dbus_be_o    = dbus_be_q;
    assign dbus_wdata_o = dbus_wdata_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_data_o    = rd_data_q;
    assign rd_we_o      = rd_we_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the five-stage core, directly downstream of the execute stage.
- Consumes the registered execute outputs (rd info, ALU result or store data, effective address, re/we, funct3).
- Performs load/store on a single-outstanding req/ack data bus and registers the writeback bundle.
- Stalls upstream while a bus access is in flight.

Parameters:
- XLEN, `XLEN (32): data/address width.
- TIMEOUT_CYCLES, 255: BUSY cycles without ack before abort; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low (0 = reset).
- rd_addr_i  in  5  destination register.
- rd_data_i  in  XLEN  ALU result; store data when mem_we_i=1.
- rd_we_i  in  1  register write enable.
- mem_addr_i  in  XLEN  effective byte address.
- mem_re_i  in  1  load request.
- mem_we_i  in  1  store request.
- opfunc3_i  in  3  load/store width and sign.
- stall_o  out  1  freeze upstream pipeline registers (combinational).
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  1 = write.
- dbus_addr_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  XLEN  lane-replicated store data.
- dbus_ack_i  in  1  access complete; rdata valid the same cycle.
- dbus_rdata_i  in  XLEN  read word.
- rd_addr_o  out  5  to WB and forwarding.
- rd_data_o  out  XLEN  to WB and forwarding.
- rd_we_o  out  1  to WB and forwarding.
- misalign_o  out  1  one-cycle pulse: misaligned or illegal access.
- bus_err_o  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (rst_i=0 at a clk edge): state=IDLE, counter=0. All registered outputs are 0: rd_*_o, dbus_req_o, dbus_we_o, dbus_addr_o, dbus_be_o, dbus_wdata_o, misalign_o, bus_err_o.
- Reset mid-access: dbus_req_o is low after the reset edge; the abandoned transfer is dropped and a late ack is ignored.
- States: IDLE and BUSY.
- IDLE, no mem op: rd_*_o <= inputs at the next edge (1-cycle latency). stall_o=0.
- IDLE, mem op (re|we): if both are set, the access is a store and re is ignored.
- Access checks:
  - Store funct3: 000 SB, 001 SH, 010 SW.
  - Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Illegal: any other funct3.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- IDLE, illegal or misaligned op: no bus request. misalign_o=1 for one cycle, rd_we_o <= 0, stall_o=0.
- IDLE, legal op: stall_o=1 combinationally. At the edge, latch the request into dbus_* regs, capture rd_addr/rd_we/funct3/addr[1:0], set dbus_req_o=1, clear the counter, go to BUSY. rd_we_o <= 0 (bubble).
- Byte enables and write data:
  - SB: be = 0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011<<addr[1:0], wdata = half replicated x2.
  - SW: be = 1111, wdata unchanged.
  - Loads: be per the same width rule; wdata = 0.
- BUSY: dbus_* outputs held stable; stall_o=1 except in the ack cycle; inputs ignored.
- BUSY, ack: stall_o=0 combinationally. At the edge:
  - dbus_req_o <= 0, state <= IDLE.
  - Load: rd_data_o <= extended lane selected by the captured addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
  - Store: rd_we_o <= 0. rd_addr_o and rd_data_o retain their previous values.
  - Ack in the first BUSY cycle is legal (minimum load latency: 2 cycles from input to rd_data_o).
- BUSY timeout: counter increments each BUSY cycle without ack. When counter==TIMEOUT_CYCLES-1 with no ack, abort at the next edge: req <= 0, bus_err_o pulses, rd_we_o <= 0, state <= IDLE. stall_o=0 in that cycle.
- Ack coinciding with the timeout cycle: ack wins and there is no error.
- Ack outside BUSY: ignored.
- x0: a load with rd_addr=0 still performs the bus access; rd_we_o passes through as given (WB ignores x0).
- Back-to-back mem ops: the next op is accepted in the IDLE cycle after ack; there is no combinational ack-to-req path.

Decomposition:
- Shared package/defines: funct3 load/store encodings, FSM state encoding, and `XLEN (already in defines.v).
- One sub-module is natural: mem_lane_align. It is pure combinational and produces be, wdata replication, and load lane extract plus extend. It is reused by a future D-cache.

Test Plan:
- ALU pass-through: rd_addr=5, data=0x1234, we=1, no mem op -> next cycle rd_*_o match, stall_o=0, dbus_req_o=0.
- LB: addr=0x103, rdata=0x80FFFFFF, ack on the 1st BUSY cycle -> be=1000, dbus_addr=0x100, rd_data_o=0xFFFFFF80, stall high 1 cycle. Repeat as LBU -> 0x00000080.
- SH: addr=0x22, rd_data_i=0xABCD1234, ack after 3 cycles -> be=1100, wdata=0x12341234, req held 3 cycles, rd_we_o=0.
- Misaligned LW at 0x102 -> no req, misalign_o pulse, rd_we_o=0. Same for funct3=011 -> misalign_o pulse.
- Timeout: TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, bus_err_o pulse, stall released, state IDLE. Ack on the 4th cycle -> no bus_err_o.
- rst_i=0 asserted in BUSY -> all outputs 0 next edge. A later ack is ignored, and a fresh load after reset completes normally.
